// File: rtl/qc_block_rotator.sv
// qc_block_rotator: pipelined circular rotator for QC-LDPC lifting.
// Rotates the low Z bits of a MAXZ-wide word by a runtime shift amount, in either direction.
// Ports:
//   CLK, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_data, in_z       data word and runtime lifting size (1..MAXZ)
//   in_shift, in_dir    rotation amount (0..Z-1); 0 = right, 1 = left
//   in_tag              sideband carried alongside the beat
//   out_valid/out_ready output handshake
//   out_data, out_tag   rotated word (zero above Z), tag of the beat
//   out_err             illegal Z or shift seen for this beat (data forced to 0)
module qc_block_rotator #(
  parameter int unsigned MAXZ                  = 81,
  parameter int unsigned PIPE_STAGES_PER_CYCLE = 1,
  parameter int unsigned TAG_W                 = 8,
  localparam int unsigned ZW                   = $clog2(MAXZ + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAXZ-1:0]  in_data,
  input  logic [ZW-1:0]    in_z,
  input  logic [ZW-1:0]    in_shift,
  input  logic             in_dir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAXZ-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int unsigned NL = $clog2(MAXZ);
  localparam int unsigned NS = (NL + PIPE_STAGES_PER_CYCLE - 1) / PIPE_STAGES_PER_CYCLE;

  typedef logic [MAXZ-1:0] word_t;
  typedef logic [ZW-1:0]   amt_t;

  // Low-Z-bit mask; a Z at or above MAXZ yields all ones.
  function automatic word_t mask_of(input amt_t z);
    return ~({MAXZ{1'b1}} << z);
  endfunction

  // Logical right shift using the mux levels base..base+P-1 of amount a.
  function automatic word_t shr_lv(input word_t d, input amt_t a, input int unsigned base);
    word_t t;
    amt_t  sh;
    t = d;
    for (int unsigned j = 0; j < PIPE_STAGES_PER_CYCLE; j++) begin
      sh = a >> (base + j);
      if ((base + j) < NL && sh[0]) t = t >> (32'd1 << (base + j));
    end
    return t;
  endfunction

  // Logical left shift using the mux levels base..base+P-1 of amount a.
  function automatic word_t shl_lv(input word_t d, input amt_t a, input int unsigned base);
    word_t t;
    amt_t  sh;
    t = d;
    for (int unsigned j = 0; j < PIPE_STAGES_PER_CYCLE; j++) begin
      sh = a >> (base + j);
      if ((base + j) < NL && sh[0]) t = t << (32'd1 << (base + j));
    end
    return t;
  endfunction

  // Mux-stage registers: index 0 is the input register, NS-1 feeds the output register.
  logic [NS-1:0]    vld_q, vld_d;
  word_t            rw_q  [NS];
  word_t            rw_d  [NS];
  word_t            lw_q  [NS];
  word_t            lw_d  [NS];
  amt_t             r_q   [NS];
  amt_t             r_d   [NS];
  amt_t             l_q   [NS];
  amt_t             l_d   [NS];
  amt_t             z_q   [NS];
  amt_t             z_d   [NS];
  logic [TAG_W-1:0] tag_q [NS];
  logic [TAG_W-1:0] tag_d [NS];
  logic [NS-1:0]    err_q, err_d;

  logic             out_valid_q;
  word_t            out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_err_q;

  logic  err_in;
  amt_t  r_in, l_in;
  word_t word_in;

  // The whole pipeline advances together, so one stall signal covers every stage.
  assign in_ready = !out_valid_q || out_ready;

  // Input decode: legality, right/left amounts, masked word.
  always_comb begin
    err_in  = (in_z == '0) || (32'(in_z) > MAXZ) || (in_shift >= in_z);
    r_in    = in_dir ? ((in_shift == '0) ? '0 : ZW'(in_z - in_shift)) : in_shift;
    // l == Z only when r == 0, and then the right path alone already gives the identity.
    l_in    = ZW'(in_z - r_in);
    word_in = err_in ? '0 : (in_data & mask_of(in_z));
  end

  // Next-state for the stage registers and the combined output word.
  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    vld_d[0] = in_valid;
    rw_d[0]  = word_in;
    lw_d[0]  = word_in;
    r_d[0]   = r_in;
    l_d[0]   = l_in;
    z_d[0]   = in_z;
    tag_d[0] = in_tag;
    err_d[0] = err_in;
    for (int unsigned s = 1; s < NS; s++) begin
      vld_d[s] = vld_q[s-1];
      rw_d[s]  = shr_lv(rw_q[s-1], r_q[s-1], (s - 1) * PIPE_STAGES_PER_CYCLE);
      lw_d[s]  = shl_lv(lw_q[s-1], l_q[s-1], (s - 1) * PIPE_STAGES_PER_CYCLE);
      r_d[s]   = r_q[s-1];
      l_d[s]   = l_q[s-1];
      z_d[s]   = z_q[s-1];
      tag_d[s] = tag_q[s-1];
      err_d[s] = err_q[s-1];
    end
    // Last mux level, then merge both halves and drop bits the left shift pushed past Z.
    out_data_d = (shr_lv(rw_q[NS-1], r_q[NS-1], (NS - 1) * PIPE_STAGES_PER_CYCLE) |
                  shl_lv(lw_q[NS-1], l_q[NS-1], (NS - 1) * PIPE_STAGES_PER_CYCLE)) &
                 mask_of(z_q[NS-1]);
  end

  // Pipeline registers; reset wins over stall.
  always_ff @(posedge CLK) begin
    if (rst) begin
      vld_q       <= '0;
      err_q       <= '0;
      for (int unsigned s = 0; s < NS; s++) begin
        rw_q[s]  <= '0;
        lw_q[s]  <= '0;
        r_q[s]   <= '0;
        l_q[s]   <= '0;
        z_q[s]   <= '0;
        tag_q[s] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (in_ready) begin
      vld_q       <= vld_d;
      err_q       <= err_d;
      for (int unsigned s = 0; s < NS; s++) begin
        rw_q[s]  <= rw_d[s];
        lw_q[s]  <= lw_d[s];
        r_q[s]   <= r_d[s];
        l_q[s]   <= l_d[s];
        z_q[s]   <= z_d[s];
        tag_q[s] <= tag_d[s];
      end
      out_valid_q <= vld_q[NS-1];
      out_data_q  <= out_data_d;
      out_tag_q   <= tag_q[NS-1];
      out_err_q   <= err_q[NS-1];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule
